// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes over a 128-bit state.
// Define INV_SUB_BYTES_FWD_EN to add a per-block mode port for the forward S-box.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] instate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] outstate,
    output logic         busy
);

    localparam int B = BYTES_PER_CYCLE;
    localparam int N = 16 / B;
    localparam logic [3:0] LAST = 4'(N - 1);

    localparam logic [0:255][7:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [0:255][7:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [3:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic         in_ready_q;
    logic         busy_q;
    logic         out_valid_q;
`ifdef INV_SUB_BYTES_FWD_EN
    logic         mode_q;
`endif

    function automatic logic [7:0] sbox(input logic [7:0] x);
`ifdef INV_SUB_BYTES_FWD_EN
        return mode_q ? FWD_TBL[x] : INV_TBL[x];
`else
        return INV_TBL[x];
`endif
    endfunction

    // Substitute the bytes of the current chunk, pass the rest through.
    always_comb begin
        work_d = work_q;
        for (int j = 0; j < B; j++) begin
            work_d[(int'(cnt_q) * B + j) * 8 +: 8] =
                sbox(work_q[(int'(cnt_q) * B + j) * 8 +: 8]);
        end
    end

    // Control FSM with registered handshake outputs and working register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= instate;
                        cnt_q      <= 4'd0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
                        mode_q     <= mode;
`endif
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign outstate  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Testbench for inv_sub_bytes_iter: three instances (4, 1, 16 bytes/cycle)
// checked against an S-box model derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

    localparam int BPC [3] = '{4, 1, 16};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   iv = '0;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   ordy = '0;
    logic [2:0]   bsy;
    logic [2:0]   md = '0;
    logic [127:0] ist [3];
    logic [127:0] ost [3];

    int checks = 0;
    int failures = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC[g])) u_dut (
            .clk       (clk),
            .reset     (reset),
`ifdef INV_SUB_BYTES_FWD_EN
            .mode      (md[g]),
`endif
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .instate   (ist[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .outstate  (ost[g]),
            .busy      (bsy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic fwd);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[k*8 +: 8] = fwd ? sb[s[k*8 +: 8]] : isb[s[k*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input int d, input logic [127:0] din,
                             input logic m, input string nm,
                             output logic [127:0] dout);
        int lat;
        int n;
        n = 16 / BPC[d];
        @(negedge clk);
        checks++;
        if (ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready got=%b want=1", nm, ir[d]);
        end
        ist[d] = din;
        md[d] = m;
        iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        ist[d] = rnd128();
        md[d] = ~m;
        checks++;
        if (bsy[d] !== 1'b1 || ir[d] !== 1'b0 || ov[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_flags got=%b%b%b want=100", nm, bsy[d], ir[d], ov[d]);
        end
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != n) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", nm, lat, n);
        end
        dout = ost[d];
        @(negedge clk);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s consume got ov=%b ir=%b want ov=0 ir=1", nm, ov[d], ir[d]);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || bsy[d] !== 1'b0 || ost[d] !== '0) begin
                failures++;
                $display("FAIL reset_out dut%0d got ov=%b busy=%b out=%h want 0", d, ov[d], bsy[d], ost[d]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready dut%0d got=%b want=1", d, ir[d]);
            end
        end
    endtask

    task automatic test_all63();
        logic [127:0] r;
        run_block(0, {16{8'h63}}, 1'b0, "all63", r);
        checks++;
        if (r !== '0) begin
            failures++;
            $display("FAIL all63 got=%h want=0", r);
        end
    endtask

    task automatic test_fips();
        logic [127:0] r;
        run_block(0, 128'h63CAB7040953D051CD60E0E7BA70E18C, 1'b0, "fips", r);
        checks++;
        if (r !== 128'h00102030405060708090A0B0C0D0E0F0) begin
            failures++;
            $display("FAIL fips got=%h want=00102030405060708090a0b0c0d0e0f0", r);
        end
    endtask

    task automatic test_random();
        logic [127:0] x;
        logic [127:0] r;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
                x = rnd128();
                run_block(d, x, 1'b0, "random", r);
                checks++;
                if (r !== model(x, 1'b0)) begin
                    failures++;
                    $display("FAIL random dut%0d in=%h got=%h want=%h", d, x, r, model(x, 1'b0));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] x;
        int lat;
        int seen;
        x = rnd128();
        @(negedge clk);
        ist[0] = x;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            ist[0] = rnd128();
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || ost[0] !== model(x, 1'b0)) begin
                failures++;
                $display("FAIL stall cyc%0d got ov=%b ir=%b out=%h want ov=1 ir=0 out=%h",
                         c, ov[0], ir[0], ost[0], model(x, 1'b0));
            end
            @(negedge clk);
            ist[0] = rnd128();
            @(posedge clk); #1;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL stall_no_accept got=%0d bad cycles want=0", seen);
        end
    endtask

    task automatic test_early_ready();
        logic [127:0] x;
        int lat;
        x = rnd128();
        @(negedge clk);
        ordy[0] = 1'b1;
        ist[0] = x;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 4 || ost[0] !== model(x, 1'b0)) begin
            failures++;
            $display("FAIL early_ready got lat=%0d out=%h want lat=4 out=%h", lat, ost[0], model(x, 1'b0));
        end
        @(posedge clk); #1;
        checks++;
        if (ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL early_ready_consume got=%b want=0", ov[0]);
        end
        @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] x;
        int rises[$];
        int bad;
        x = rnd128();
        bad = 0;
        @(negedge clk);
        ist[0] = x;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ov[0] === 1'b1) begin
                rises.push_back(c);
                if (ost[0] !== model(x, 1'b0)) bad++;
            end
        end
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        ordy[0] = 1'b0;
        checks++;
        if (rises.size() < 5 || bad != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d blocks bad=%0d want>=5 bad=0", rises.size(), bad);
        end
        for (int i = 1; i < rises.size(); i++) begin
            checks++;
            if (rises[i] - rises[i-1] != 6) begin
                failures++;
                $display("FAIL b2b_gap got=%0d want=6", rises[i] - rises[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        ist[0] = rnd128();
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ost[0] !== '0 || bsy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got ov=%b busy=%b out=%h want 0", ov[0], bsy[0], ost[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready got=%b want=1", ir[0]);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (ov[0] !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_stale got=%0d valid cycles want=0", seen);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] x;
        logic [127:0] r;
        for (int d = 1; d < 3; d++) begin
            for (int b = 0; b < 16; b++) begin
                for (int k = 0; k < 16; k++) x[k*8 +: 8] = 8'(b * 16 + k);
                run_block(d, x, 1'b0, "sweep", r);
                checks++;
                if (r !== model(x, 1'b0)) begin
                    failures++;
                    $display("FAIL sweep dut%0d blk%0d got=%h want=%h", d, b, r, model(x, 1'b0));
                end
            end
        end
    endtask

`ifdef INV_SUB_BYTES_FWD_EN
    task automatic test_fwd_roundtrip();
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] z;
        for (int i = 0; i < 4; i++) begin
            x = rnd128();
            run_block(0, x, 1'b1, "fwd", y);
            run_block(0, y, 1'b0, "fwd_inv", z);
            checks++;
            if (y !== model(x, 1'b1) || z !== x) begin
                failures++;
                $display("FAIL fwd_roundtrip in=%h fwd=%h back=%h want fwd=%h back=%h",
                         x, y, z, model(x, 1'b1), x);
            end
        end
    endtask
`endif

    initial begin
        for (int d = 0; d < 3; d++) ist[d] = '0;
        build_model();
        test_reset();
        test_all63();
        test_fips();
        test_random();
        test_stall();
        test_early_ready();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
`ifdef INV_SUB_BYTES_FWD_EN
        test_fwd_roundtrip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL provide parameter BYTES_PER_CYCLE, default 4, meaning state bytes inverse-substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  instate holds a block to be accepted.
REQ-005 SHALL provide port in_ready  output  1  block can be accepted this cycle.
REQ-006 SHALL provide port instate  input  128  AES state; byte k = instate[8k+7:8k].
REQ-007 SHALL provide port out_valid  output  1  outstate holds a completed result.
REQ-008 SHALL provide port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL provide port outstate  output  128  result; byte k = InvS(instate byte k).
REQ-010 SHALL provide port busy  output  1  high while substitution is in progress.

Function
REQ-011 SHALL implement InvS as the FIPS-197 inverse S-box, the exact inverse of the team's forward SubBytes table, e.g. InvS(63)=00, InvS(00)=52, InvS(16)=FF.
REQ-012 SHALL use states IDLE, BUSY, DONE; in_ready=1 only in IDLE, busy=1 only in BUSY, out_valid=1 only in DONE.
REQ-013 SHALL accept a block on a rising edge with in_valid=1 and in_ready=1: capture instate into the working register, clear chunk counter, go to BUSY.
REQ-014 SHALL, in BUSY, replace working bytes [c*B .. c*B+B-1] with their InvS values on each edge, B=BYTES_PER_CYCLE, c=chunk counter 0..N-1, N=16/B.
REQ-015 SHALL go BUSY->DONE on the edge processing chunk N-1, so out_valid rises exactly N cycles after the accepting edge (N=4 at default).
REQ-016 SHALL hold outstate stable and out_valid high in DONE until an edge with out_ready=1, then go DONE->IDLE.
REQ-017 SHALL ignore in_valid and instate changes outside IDLE; no block is dropped or overwritten.
REQ-018 SHALL allow out_ready high before DONE without effect; out_ready=1 on the DONE-entry edge is not consumed early.
REQ-019 SHALL sustain one block per N+2 cycles with in_valid and out_ready held high.
REQ-020 SHALL drive outstate from the working register; its contents outside DONE are don't-care except for the reset value.

Reset
REQ-021 SHALL, on reset assertion, asynchronously force state IDLE, chunk counter 0, working register 0, out_valid=0, busy=0, outstate=0.
REQ-022 SHALL drive in_ready=1 from reset deassertion onward (IDLE).
REQ-023 SHALL discard any in-flight block when reset asserts mid-BUSY or mid-DONE; no out_valid follows for it.

Configuration
REQ-024 SHALL recognise macro INV_SUB_BYTES_FWD_EN.
REQ-025 SHALL, with INV_SUB_BYTES_FWD_EN defined, add port mode  input  1, sampled only on the accept edge; mode=1 applies forward S-box, mode=0 applies InvS, for the whole block.
REQ-026 SHALL, without INV_SUB_BYTES_FWD_EN, omit port mode and forward table; InvS always applied.

Verification
REQ-027 SHALL cover: instate=all bytes 63 -> outstate=0, out_valid high 4 cycles after accept (default parameter).
REQ-028 SHALL cover: FIPS-197 vector instate=63CAB7040953D051CD60E0E7BA70E18C -> outstate=00102030405060708090A0B0C0D0E0F0.
REQ-029 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outstate unchanged, in_ready=0, new in_valid block not accepted.
REQ-030 SHALL cover: reset pulsed 2 cycles after accept -> out_valid=0, outstate=0, in_ready=1 next cycle, no stale result.
REQ-031 SHALL cover: BYTES_PER_CYCLE=1 and 16 with exhaustive 256-byte sweep (16 blocks) -> each byte equals InvS, latency 16 and 1 cycles respectively.
REQ-032 SHALL cover: with INV_SUB_BYTES_FWD_EN, mode=1 then mode=0 on result -> original instate recovered.
